// File: rtl/gate_bist.sv
// gate_bist: self-test engine for a 2-input bitwise gate block.
// Walks every {a,b} vector, waits SETTLE_CYCLES, samples y and compares it
// against the expected GATE_OP function, counting mismatches.
// Optional build macro: GATE_BIST_STOP_ON_FAIL_EN -- end the run at the first
// mismatch instead of sweeping all vectors.
module gate_bist #(
  parameter int WIDTH         = 1,
  parameter int SETTLE_CYCLES = 2,
  parameter int GATE_OP       = 0,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [WIDTH-1:0]       a,
  output logic [WIDTH-1:0]       b,
  input  logic [WIDTH-1:0]       y,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_CNT_W-1:0]   err_count,
  output logic [2*WIDTH-1:0]     first_fail_vec
);

  localparam int VW = 2 * WIDTH;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_APPLY  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [VW-1:0]        vec_q, vec_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic [VW-1:0]        ffv_q, ffv_d;

  logic [WIDTH-1:0]     exp_y;
  logic                 mismatch;
  logic                 stop_now;

  // Expected gate response for the vector currently driven on a/b
  always_comb begin
    exp_y = '0;
    case (GATE_OP)
      0:       exp_y = a_q & b_q;
      1:       exp_y = a_q | b_q;
      2:       exp_y = a_q ^ b_q;
      default: exp_y = ~(a_q & b_q);
    endcase
    mismatch = (y != exp_y);
  end

  // Sequencer next-state: vector walk, settle countdown, check and scoring
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    stop_now = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_d   = '0;
          err_d   = '0;
          ffv_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        {a_d, b_d} = vec_q;
        cnt_d      = 4'(SETTLE_CYCLES);
        state_d    = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q <= 4'd1) state_d = S_CHECK;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_CHECK: begin
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + ERR_CNT_W'(1);
          // the counter saturates and never wraps, so zero means no prior miss
          if (err_q == '0) ffv_d = {a_q, b_q};
`ifdef GATE_BIST_STOP_ON_FAIL_EN
          stop_now = 1'b1;
`else
          stop_now = 1'b0;
`endif
        end
        if (stop_now || (vec_q == '1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          vec_d   = vec_q + VW'(1);
          state_d = S_APPLY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffv_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
    end
  end

  assign a              = a_q;
  assign b              = b_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_gate_bist.sv
// tb_gate_bist: two gate_bist instances (1-bit AND with settle 2, and 2-bit
// NAND with settle 0 and a 2-bit error counter) driven by a gate model whose
// per-vector faults are chosen by the bench.
module tb_gate_bist;

  localparam int W0 = 1, S0 = 2, OP0 = 0, E0 = 8, N0 = 4;
  localparam int W1 = 2, S1 = 0, OP1 = 3, E1 = 2, N1 = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start0 = 1'b0, start1 = 1'b0;
  logic [W0-1:0]     a0, b0, y0;
  logic [W1-1:0]     a1, b1, y1;
  logic              busy0, done0, pass0, busy1, done1, pass1;
  logic [E0-1:0]     err0;
  logic [E1-1:0]     err1;
  logic [2*W0-1:0]   ffv0;
  logic [2*W1-1:0]   ffv1;

  logic [W0-1:0]     fault0 [N0];
  logic [W1-1:0]     fault1 [N1];

  int checks = 0;
  int errors = 0;
  int sel = 0;
  int ab_c, busy_c, done_c, pass_c, err_c, ffv_c;

  gate_bist #(.WIDTH(W0), .SETTLE_CYCLES(S0), .GATE_OP(OP0), .ERR_CNT_W(E0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_fail_vec(ffv0));

  gate_bist #(.WIDTH(W1), .SETTLE_CYCLES(S1), .GATE_OP(OP1), .ERR_CNT_W(E1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_fail_vec(ffv1));

  function automatic int ideal(input int op, input int av, input int bv, input int w);
    int m;
    m = (1 << w) - 1;
    case (op)
      0:       return av & bv;
      1:       return av | bv;
      2:       return av ^ bv;
      default: return (~(av & bv)) & m;
    endcase
  endfunction

  // gate under test: ideal response with a per-vector xor fault
  always_comb y0 = W0'(ideal(OP0, int'(a0), int'(b0), W0)) ^ fault0[{a0, b0}];
  always_comb y1 = W1'(ideal(OP1, int'(a1), int'(b1), W1)) ^ fault1[{a1, b1}];

  // view of whichever instance is under test
  always_comb begin
    if (sel == 0) begin
      ab_c = int'({a0, b0}); busy_c = int'(busy0); done_c = int'(done0);
      pass_c = int'(pass0); err_c = int'(err0); ffv_c = int'(ffv0);
    end else begin
      ab_c = int'({a1, b1}); busy_c = int'(busy1); done_c = int'(done1);
      pass_c = int'(pass1); err_c = int'(err1); ffv_c = int'(ffv1);
    end
  end

  // mode 0: fault-free, 1: random faults, 2: y stuck at value v
  task automatic set_faults(input int s, input int mode, input int v);
    for (int i = 0; i < N0; i++) begin
      if (mode == 0)      fault0[i] = '0;
      else if (mode == 2) fault0[i] = W0'(ideal(OP0, i >> W0, i & ((1 << W0) - 1), W0) ^ v);
      else if (s == 0)    fault0[i] = ($urandom_range(0, 2) == 0) ? W0'($urandom_range(1, (1 << W0) - 1)) : '0;
    end
    for (int i = 0; i < N1; i++) begin
      if (mode == 0)      fault1[i] = '0;
      else if (mode == 2) fault1[i] = W1'(ideal(OP1, i >> W1, i & ((1 << W1) - 1), W1) ^ v);
      else if (s == 1)    fault1[i] = ($urandom_range(0, 2) == 0) ? W1'($urandom_range(1, (1 << W1) - 1)) : '0;
    end
  endtask

  task automatic pulse_start(input int s, input logic v);
    if (s == 0) start0 = v; else start1 = v;
  endtask

  // one full run on instance s; restart_k != 0 re-pulses start on that edge
  task automatic run(input int s, input int restart_k);
    int n, cyc, emax, n_bad, first, exp_err, exp_done, exp_last, done_k, fv;
    sel   = s;
    n     = (s == 0) ? N0 : N1;
    cyc   = ((s == 0) ? S0 : S1) + 2;
    emax  = (1 << ((s == 0) ? E0 : E1)) - 1;
    n_bad = 0;
    first = -1;
    for (int i = 0; i < n; i++) begin
      fv = (s == 0) ? int'(fault0[i]) : int'(fault1[i]);
      if (fv != 0) begin
        n_bad++;
        if (first < 0) first = i;
      end
    end
`ifdef GATE_BIST_STOP_ON_FAIL_EN
    if (first >= 0) begin
      exp_err = 1; exp_done = (first + 1) * cyc + 1; exp_last = first;
    end else begin
      exp_err = 0; exp_done = n * cyc + 1; exp_last = n - 1;
    end
`else
    exp_err  = (n_bad > emax) ? emax : n_bad;
    exp_done = n * cyc + 1;
    exp_last = n - 1;
`endif
    done_k = -1;
    @(negedge clk) pulse_start(s, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (busy_c !== 1 || done_c !== 0) begin
      errors++;
      $display("FAIL accept s=%0d busy=%0d done=%0d required busy=1 done=0", s, busy_c, done_c);
    end
    for (int k = 2; k <= exp_done + 10 && done_k < 0; k++) begin
      @(negedge clk) pulse_start(s, (k == restart_k) ? 1'b1 : 1'b0);
      @(posedge clk); #1;
      if (k < exp_done && (k - 2) % cyc == 0) begin
        checks++;
        if (ab_c !== (k - 2) / cyc) begin
          errors++;
          $display("FAIL vector s=%0d k=%0d ab=%0d required %0d", s, k, ab_c, (k - 2) / cyc);
        end
      end
      if (done_c == 1) done_k = k;
    end
    @(negedge clk) pulse_start(s, 1'b0);
    checks++;
    if (done_k != exp_done) begin
      errors++;
      $display("FAIL done_time s=%0d got %0d required %0d", s, done_k, exp_done);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done_c !== 1 || busy_c !== 0) begin
      errors++;
      $display("FAIL done_hold s=%0d done=%0d busy=%0d required done=1 busy=0", s, done_c, busy_c);
    end
    checks++;
    if (err_c !== exp_err) begin
      errors++;
      $display("FAIL err_count s=%0d got %0d required %0d", s, err_c, exp_err);
    end
    checks++;
    if (pass_c !== int'(exp_err == 0)) begin
      errors++;
      $display("FAIL pass s=%0d got %0d required %0d", s, pass_c, exp_err == 0);
    end
    checks++;
    if (ffv_c !== ((first < 0) ? 0 : first)) begin
      errors++;
      $display("FAIL first_fail_vec s=%0d got %0d required %0d", s, ffv_c, (first < 0) ? 0 : first);
    end
    checks++;
    if (ab_c !== exp_last) begin
      errors++;
      $display("FAIL last_vec s=%0d got %0d required %0d", s, ab_c, exp_last);
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if ({a0, b0, busy0, done0, pass0, err0, ffv0} !== '0 ||
        {a1, b1, busy1, done1, pass1, err1, ffv1} !== '0) begin
      errors++;
      $display("FAIL %s dut0 ab=%0d busy=%0d done=%0d pass=%0d err=%0d ffv=%0d dut1 ab=%0d busy=%0d done=%0d err=%0d required all 0",
               tag, {a0, b0}, busy0, done0, pass0, err0, ffv0, {a1, b1}, busy1, done1, err1);
    end
  endtask

  task automatic test_reset();
    set_faults(0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ideal();
    set_faults(0, 0, 0);
    run(0, 0);
  endtask

  task automatic test_stuck_high();
    set_faults(0, 2, 1);
    run(0, 0);
  endtask

  task automatic test_restart_ignored();
    set_faults(0, 2, 1);
    run(0, 8);
    set_faults(0, 0, 0);
    run(0, 0);
  endtask

  task automatic test_reset_mid_run();
    set_faults(0, 2, 1);
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid");
    repeat (3) @(negedge clk);
    check_zero("reset_hold");
    rst_n = 1'b1;
    set_faults(0, 0, 0);
    run(0, 0);
  endtask

  task automatic test_saturate();
    set_faults(1, 2, 0);
    run(1, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int s;
      s = int'($urandom_range(0, 1));
      set_faults(s, 1, 0);
      run(s, (it % 3 == 0) ? 6 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_stuck_high();
    test_restart_ignored();
    test_reset_mid_run();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_bist.md
Name: gate_bist

Overview:
- Hardware self-test engine for a 2-input logic gate block; the synthesizable stimulus-and-check end of a gate interface (drives a/b, samples y).
- Sits beside the gate under test; a controller pulses start and reads pass/err_count when done rises.
- Applies every {a,b} combination, waits a settle window, compares y against the expected gate function, and counts mismatches.

Parameters:
- WIDTH, 1, bit width of a, b, y (legal 1..4); vector space N = 2^(2*WIDTH).
- SETTLE_CYCLES, 2, idle cycles between applying a vector and sampling y (legal 0..15).
- GATE_OP, 0, expected function: 0=AND, 1=OR, 2=XOR, 3=NAND (bitwise).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  1-cycle request to run; sampled only in IDLE/DONE.
- a  output  WIDTH  stimulus to the gate, registered.
- b  output  WIDTH  stimulus to the gate, registered.
- y  input  WIDTH  gate response.
- busy  output  1  high from the cycle after start until done rises.
- done  output  1  sticky completion flag; cleared by the next accepted start.
- pass  output  1  valid while done=1; 1 iff err_count==0.
- err_count  output  ERR_CNT_W  mismatch count, saturating at all-ones.
- first_fail_vec  output  2*WIDTH  {a,b} of the first mismatch; 0 if none.

Behaviour:
- Reset (async assert, sync release): state=IDLE, a=b=0, busy=done=pass=0, err_count=0, first_fail_vec=0, vec=0.
- FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE/DONE + start=1: vec=0, err_count=0, first_fail_vec=0, done=pass=0, busy=1 -> APPLY.
- APPLY (1 cycle): {a,b} <= vec (a = upper WIDTH bits); settle counter loaded with SETTLE_CYCLES -> SETTLE, or -> CHECK if SETTLE_CYCLES==0.
- SETTLE: count down; -> CHECK when the counter reaches 1.
- CHECK (1 cycle): compare y with GATE_OP(a,b). On mismatch, err_count++ (held at all-ones). On the first mismatch, first_fail_vec <= {a,b}. If vec==N-1 -> DONE, else vec++ -> APPLY.
- DONE: busy=0, done=1, pass=(err_count==0); a/b hold the last vector. Stays in DONE until start.
- Cycles per vector = SETTLE_CYCLES+2. done rises N*(SETTLE_CYCLES+2)+1 cycles after the start edge.
- start while busy is ignored: no restart, no counter effect.
- Reset mid-run aborts immediately to reset values; no partial done.
- y is sampled only in CHECK; y changes at other times are ignored.

Optional Feature:
- Macro GATE_BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CHECK goes directly to DONE with err_count=1, pass=0, first_fail_vec set, and the remaining vectors are skipped.
- Undefined: all N vectors always run; err_count is the total (saturating) mismatch count.

Test Plan:
- Ideal AND, WIDTH=1, SETTLE=2; start pulse at edge 0 -> a/b sequence 00,01,10,11; done=1 at cycle 17; pass=1; err_count=0; first_fail_vec=0.
- y stuck at 1, GATE_OP=0, WIDTH=1 -> err_count=3, first_fail_vec=2'b00, pass=0; with GATE_BIST_STOP_ON_FAIL_EN -> done at cycle 5, err_count=1.
- start pulsed again at cycle 8 of a run -> ignored; done still at cycle 17 with unchanged results; a later start from DONE clears done and reruns.
- rst_n low at cycle 9 mid-run -> all outputs 0 within the same cycle; no done; a fresh start afterwards completes normally.
- ERR_CNT_W=2, WIDTH=2, y stuck at 0 with GATE_OP=3 (NAND) -> 16 vectors, 15 mismatches, err_count saturates at 3; SETTLE=0 gives done at cycle 16*2+1=33.
